// File: rtl/door_ctrl.sv
// Elevator door controller: Moore FSM sequencing the door motor and the external
// 3 s / 5 s delay timers, with reopen counting and nudge mode.
module door_ctrl #(
    parameter int unsigned NUDGE_LIMIT = 4
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       arrive,
    input  logic       btn_open,
    input  logic       btn_close,
    input  logic       obstruct,
    input  logic       delay_3s_done,
    input  logic       delay_5s_done,
    output logic       delay_3s,
    output logic       delay_5s,
    output logic       door_open_cmd,
    output logic       door_close_cmd,
    output logic       door_closed,
    output logic       nudge,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        CLOSED   = 3'd0,
        OPENING  = 3'd1,
        OPEN     = 3'd2,
        HOLD_RST = 3'd3,
        CLOSING  = 3'd4,
        REVERSE  = 3'd5
    } state_t;

    localparam logic [2:0] LIMIT = 3'(NUDGE_LIMIT);

    state_t     state_q, state_d;
    logic [2:0] reopen_q, reopen_d;
    logic       delay_3s_q, delay_5s_q, open_cmd_q, close_cmd_q, closed_q, nudge_q;
    logic       reopen_req;

    // Once nudged, the obstruction sensor no longer reopens the door; the button still does.
    assign reopen_req = btn_open | (obstruct & ~nudge_q);

    always_comb begin
        state_d  = state_q;
        reopen_d = reopen_q;
        case (state_q)
            CLOSED: begin
                if (arrive || btn_open) state_d = OPENING;
            end
            OPENING: begin
                if (delay_3s_done) state_d = OPEN;
            end
            OPEN: begin
                if (reopen_req)                      state_d = HOLD_RST;
                else if (btn_close || delay_5s_done) state_d = CLOSING;
            end
            HOLD_RST: state_d = OPEN;
            CLOSING: begin
                if (reopen_req) begin
                    state_d  = REVERSE;
                    reopen_d = (reopen_q == 3'd7) ? 3'd7 : reopen_q + 3'd1;
                end else if (delay_3s_done) begin
                    state_d  = CLOSED;
                    reopen_d = 3'd0;
                end
            end
            REVERSE: state_d = OPENING;
            default: begin
                state_d  = CLOSED;
                reopen_d = 3'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they always match state_q/reopen_q.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLOSED;
            reopen_q    <= 3'd0;
            delay_3s_q  <= 1'b0;
            delay_5s_q  <= 1'b0;
            open_cmd_q  <= 1'b0;
            close_cmd_q <= 1'b0;
            closed_q    <= 1'b1;
            nudge_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            reopen_q    <= reopen_d;
            delay_3s_q  <= (state_d == OPENING) || (state_d == CLOSING);
            delay_5s_q  <= (state_d == OPEN);
            open_cmd_q  <= (state_d == OPENING);
            close_cmd_q <= (state_d == CLOSING);
            closed_q    <= (state_d == CLOSED);
            nudge_q     <= (reopen_d >= LIMIT);
        end
    end

    assign delay_3s       = delay_3s_q;
    assign delay_5s       = delay_5s_q;
    assign door_open_cmd  = open_cmd_q;
    assign door_close_cmd = close_cmd_q;
    assign door_closed    = closed_q;
    assign nudge          = nudge_q;
    assign state          = state_q;

endmodule

// File: tb/tb_door_ctrl.sv
// Bench for door_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a behavioural model of the door rules.
module tb_door_ctrl;

    localparam int NL = 2;

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b1;
    logic       arrive = 1'b0, btn_open = 1'b0, btn_close = 1'b0, obstruct = 1'b0;
    logic       delay_3s_done = 1'b0, delay_5s_done = 1'b0;
    logic       delay_3s, delay_5s, door_open_cmd, door_close_cmd, door_closed, nudge;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #10 clk_50M = ~clk_50M;

    door_ctrl #(.NUDGE_LIMIT(NL)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .arrive(arrive), .btn_open(btn_open),
        .btn_close(btn_close), .obstruct(obstruct), .delay_3s_done(delay_3s_done),
        .delay_5s_done(delay_5s_done), .delay_3s(delay_3s), .delay_5s(delay_5s),
        .door_open_cmd(door_open_cmd), .door_close_cmd(door_close_cmd),
        .door_closed(door_closed), .nudge(nudge), .state(state)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: door position phase (0..5) and reopen count.
    int m_st = 0, m_cnt = 0, m_nxt;

    function automatic int next_phase(input int st, input int cnt, input logic a, bo, bc, ob, d3, d5);
        bit reopen;
        reopen = bo || (ob && cnt < NL);
        case (st)
            0: return (a || bo) ? 1 : 0;
            1: return d3 ? 2 : 1;
            2: return reopen ? 3 : ((bc || d5) ? 4 : 2);
            3: return 2;
            4: return reopen ? 5 : (d3 ? 0 : 4);
            5: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [5:0] exp_out(input int st, input int cnt);
        return {st == 1 || st == 4, st == 2, st == 1, st == 4, st == 0, cnt >= NL};
    endfunction

    always_comb m_nxt = next_phase(m_st, m_cnt, arrive, btn_open, btn_close, obstruct,
                                   delay_3s_done, delay_5s_done);

    always @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            m_st  <= 0;
            m_cnt <= 0;
        end else begin
            m_st <= m_nxt;
            if (m_nxt == 5 && m_st != 5)      m_cnt <= (m_cnt < 7) ? m_cnt + 1 : 7;
            else if (m_nxt == 0 && m_st != 0) m_cnt <= 0;
        end
    end

    always @(negedge clk_50M) begin
        if (cmp_en) begin
            check("model.state", state, m_st);
            check("model.outs", {delay_3s, delay_5s, door_open_cmd, door_close_cmd, door_closed, nudge},
                  exp_out(m_st, m_cnt));
            check("motor_excl", door_open_cmd & door_close_cmd, 0);
        end
    end

    // Inputs change 2 time units after the falling edge; returns once outputs have settled.
    task automatic apply(input bit a, bo, bc, ob, d3, d5);
        arrive = a; btn_open = bo; btn_close = bc; obstruct = ob;
        delay_3s_done = d3; delay_5s_done = d5;
        @(negedge clk_50M);
        #2;
    endtask

    task automatic chk(input string nm, input logic [2:0] st, input logic [5:0] outs);
        check({nm, ".state"}, state, st);
        check({nm, ".outs"}, {delay_3s, delay_5s, door_open_cmd, door_close_cmd, door_closed, nudge}, outs);
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        chk("rst_asserted", 3'd0, 6'b000010);
        arrive = 1'b1; btn_open = 1'b0; btn_close = 1'b0; obstruct = 1'b0;
        delay_3s_done = 1'b0; delay_5s_done = 1'b0;
        @(negedge clk_50M);
        #2 rst_n = 1'b1;
        #1 chk("rst_release", 3'd0, 6'b000010);
        #1;
    endtask

    initial begin
        #3;
        reset_and_release();

        // first edge after release with arrive held
        apply(1, 0, 0, 0, 0, 0); chk("first_edge", 3'd1, 6'b101000);
        apply(0, 0, 0, 0, 1, 0); chk("open",       3'd2, 6'b010000);
        apply(0, 0, 0, 0, 0, 1); chk("closing",    3'd4, 6'b100100);
        apply(0, 0, 0, 0, 1, 0); chk("closed",     3'd0, 6'b000010);
        apply(0, 0, 0, 0, 1, 1); chk("stray_done1", 3'd0, 6'b000010);
        apply(0, 0, 1, 0, 1, 1); chk("stray_done2", 3'd0, 6'b000010);

        // hold restart
        apply(1, 0, 0, 0, 0, 0); chk("opening",    3'd1, 6'b101000);
        apply(0, 0, 0, 0, 0, 0); chk("opening_hold", 3'd1, 6'b101000);
        apply(0, 0, 0, 0, 1, 0); chk("open2",      3'd2, 6'b010000);
        apply(0, 1, 0, 0, 0, 0); chk("hold_rst",   3'd3, 6'b000000);
        apply(0, 0, 0, 0, 0, 1); chk("hold_ignore_d5", 3'd2, 6'b010000);
        apply(0, 0, 0, 0, 0, 0); chk("open_stay",  3'd2, 6'b010000);
        apply(0, 0, 1, 0, 0, 0); chk("close_early", 3'd4, 6'b100100);
        apply(0, 0, 0, 0, 1, 0); chk("closed2",    3'd0, 6'b000010);

        // close with obstruction, then reversals into nudge
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0); chk("open3",      3'd2, 6'b010000);
        apply(0, 0, 1, 1, 0, 0); chk("bc_ob_hold", 3'd3, 6'b000000);
        apply(0, 0, 0, 0, 0, 0); chk("back_open",  3'd2, 6'b010000);
        apply(0, 0, 1, 0, 0, 0); chk("closing3",   3'd4, 6'b100100);
        apply(0, 0, 0, 1, 0, 0); chk("reverse1",   3'd5, 6'b000000);
        apply(0, 0, 0, 0, 0, 0); chk("reopen1",    3'd1, 6'b101000);
        apply(0, 0, 0, 0, 1, 0);
        apply(0, 0, 1, 0, 0, 0); chk("closing4",   3'd4, 6'b100100);
        apply(0, 0, 0, 1, 0, 0); chk("reverse2",   3'd5, 6'b000001);
        apply(0, 0, 0, 0, 0, 0); chk("reopen2",    3'd1, 6'b101001);
        apply(0, 0, 0, 0, 1, 0); chk("open_nudge", 3'd2, 6'b010001);
        apply(0, 0, 0, 1, 0, 0); chk("open_ob_ign", 3'd2, 6'b010001);
        apply(0, 0, 1, 0, 0, 0); chk("closing_nudge", 3'd4, 6'b100101);
        apply(0, 0, 0, 1, 0, 0); chk("closing_ob_ign", 3'd4, 6'b100101);
        apply(0, 0, 0, 0, 1, 0); chk("closed_clear", 3'd0, 6'b000010);

        // asynchronous reset in CLOSING
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0);
        apply(0, 0, 1, 0, 0, 0); chk("pre_rst_closing", 3'd4, 6'b100100);
        #5 rst_n = 1'b0;
        #1 chk("async_rst", 3'd0, 6'b000010);
        @(negedge clk_50M);
        #2 reset_and_release();

        // randomized traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            apply($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        rst_n = 1'b1;
        apply(0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
